// File: rtl/captura_pkg.sv
// captura_pkg: shared defaults and derived constants for the result capture block
package captura_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int DEPTH_DEF = 8;
   localparam int PTR_W = $clog2(DEPTH_DEF);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [15:0] PERDIDOS_MAX = 16'hFFFF;
endpackage

// File: rtl/fifo_sinc.sv
// fifo_sinc: synchronous first-word-fall-through FIFO
//   clk_i/rst_i : clock, sync active-high reset
//   push_i/dato_i : write request and data; ignored when full unless popping the same cycle
//   pop_i : read request; ignored when empty
//   dato_o : head entry, valid while vacio_o=0
//   lleno_o/vacio_o/cuenta_o : full, empty, occupancy
module fifo_sinc
   import captura_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] dato_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dato_o,
   output logic             lleno_o,
   output logic             vacio_o,
   output logic [PW:0]      cuenta_o
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [PW:0] cnt_q;
   logic push_ok, pop_ok;
   assign vacio_o = cnt_q == '0;
   assign lleno_o = cnt_q == (PW+1)'(DEPTH);
   assign cuenta_o = cnt_q;
   assign dato_o = mem[rd_q];
   assign pop_ok = pop_i && !vacio_o;
   // a full FIFO still accepts a write when the head leaves in the same cycle
   assign push_ok = push_i && (!lleno_o || pop_ok);
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_q] <= dato_i;
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + PW'(1);
         if (pop_ok) rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
      end
   end
endmodule

// File: rtl/captura_salida.sv
// captura_salida: buffers changes of a core result word into a FWFT FIFO with drop accounting
//   clk_i/rst_i : clock, sync active-high reset
//   salida_i/en_i : sampled result word and capture enable
//   dato_o/valido_o/listo_i : head word, valid, consumer accept
//   cuenta_o/lleno_o/vacio_o : occupancy, full, empty
//   desborde_o/perdidos_o : sticky drop flag, saturating drop count
module captura_salida
   import captura_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] salida_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] dato_o,
   output logic             valido_o,
   input  logic             listo_i,
   output logic [PW:0]      cuenta_o,
   output logic             lleno_o,
   output logic             vacio_o,
   output logic             desborde_o,
   output logic [15:0]      perdidos_o
);
   logic [WIDTH-1:0] prev_q;
   logic primero_q;
   logic captura, pop, store, drop;
   assign valido_o = !vacio_o;
   assign pop = valido_o && listo_i;
   // the first enabled sample is always new; afterwards only changes are captured
   assign captura = en_i && (primero_q || salida_i != prev_q);
   assign store = captura && (!lleno_o || pop);
   assign drop = captura && !store;
   fifo_sinc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .push_i(store),
      .dato_i(salida_i),
      .pop_i(pop),
      .dato_o(dato_o),
      .lleno_o(lleno_o),
      .vacio_o(vacio_o),
      .cuenta_o(cuenta_o)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q <= '0;
         primero_q <= 1'b1;
         desborde_o <= 1'b0;
         perdidos_o <= '0;
      end else begin
         if (en_i) begin
            prev_q <= salida_i;
            primero_q <= 1'b0;
         end
         if (drop) desborde_o <= 1'b1;
         if (drop && perdidos_o != PERDIDOS_MAX) perdidos_o <= perdidos_o + 16'd1;
      end
   end
endmodule

// File: tb/tb_captura_salida.sv
// tb_captura_salida: directed self-checking bench for captura_salida
module tb_captura_salida;
   logic clk = 1'b0;
   logic rst, en, listo;
   logic [31:0] salida, dato;
   logic valido, lleno, vacio, desborde;
   logic [3:0] cuenta;
   logic [15:0] perdidos;
   int checks = 0;
   int errors = 0;
   logic [31:0] drain_exp [8];
   always #5 clk = ~clk;
   captura_salida dut (
      .clk_i(clk),
      .rst_i(rst),
      .salida_i(salida),
      .en_i(en),
      .dato_o(dato),
      .valido_o(valido),
      .listo_i(listo),
      .cuenta_o(cuenta),
      .lleno_o(lleno),
      .vacio_o(vacio),
      .desborde_o(desborde),
      .perdidos_o(perdidos)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask
   initial begin
      rst = 1'b1; en = 1'b0; listo = 1'b0; salida = '0;
      tick(); tick();
      chk("rst_cuenta", 32'(cuenta), 0);
      chk("rst_valido", 32'(valido), 0);
      chk("rst_vacio", 32'(vacio), 1);
      chk("rst_lleno", 32'(lleno), 0);
      chk("rst_desborde", 32'(desborde), 0);
      chk("rst_perdidos", 32'(perdidos), 0);
      rst = 1'b0;
      en = 1'b1; salida = 32'h0;
      tick();
      chk("first_valido", 32'(valido), 1);
      chk("first_dato", dato, 0);
      chk("first_cuenta", 32'(cuenta), 1);
      tick(); tick();
      chk("held_cuenta", 32'(cuenta), 1);
      en = 1'b0; listo = 1'b1;
      tick();
      chk("drain0_vacio", 32'(vacio), 1);
      en = 1'b1; salida = 32'd1;
      tick();
      chk("seq_dato1", dato, 1);
      salida = 32'd2;
      tick();
      chk("seq_dato2", dato, 2);
      chk("seq_cuenta2", 32'(cuenta), 1);
      tick();
      chk("seq_repeat_cuenta", 32'(cuenta), 0);
      salida = 32'd3;
      tick();
      chk("seq_dato3", dato, 3);
      en = 1'b0;
      tick();
      chk("seq_end_vacio", 32'(vacio), 1);
      listo = 1'b0; en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         salida = 32'(10 + i);
         tick();
      end
      en = 1'b0;
      chk("ovf_lleno", 32'(lleno), 1);
      chk("ovf_cuenta", 32'(cuenta), 8);
      chk("ovf_perdidos", 32'(perdidos), 2);
      chk("ovf_desborde", 32'(desborde), 1);
      chk("ovf_head", dato, 10);
      en = 1'b1; salida = 32'd20; listo = 1'b1;
      tick();
      en = 1'b0;
      chk("fullpop_cuenta", 32'(cuenta), 8);
      chk("fullpop_perdidos", 32'(perdidos), 2);
      drain_exp = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17, 32'd20};
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_%0d", i), dato, drain_exp[i]);
         tick();
      end
      chk("drain_vacio", 32'(vacio), 1);
      listo = 1'b0; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         salida = 32'(30 + i);
         tick();
      end
      chk("pre_rst_cuenta", 32'(cuenta), 5);
      chk("pre_rst_desborde", 32'(desborde), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_cuenta", 32'(cuenta), 0);
      chk("mid_rst_valido", 32'(valido), 0);
      chk("mid_rst_desborde", 32'(desborde), 0);
      chk("mid_rst_perdidos", 32'(perdidos), 0);
      tick();
      chk("post_rst_capture_cuenta", 32'(cuenta), 1);
      chk("post_rst_capture_dato", dato, 34);
      en = 1'b0; listo = 1'b1;
      tick();
      listo = 1'b0; en = 1'b1; salida = 32'd5;
      tick();
      chk("en5_cuenta", 32'(cuenta), 1);
      en = 1'b0; salida = 32'd9;
      tick(); tick();
      chk("en_off_cuenta", 32'(cuenta), 1);
      en = 1'b1;
      tick();
      chk("en9_cuenta", 32'(cuenta), 2);
      tick();
      chk("en9_repeat_cuenta", 32'(cuenta), 2);
      en = 1'b0; listo = 1'b1;
      chk("en_dato5", dato, 5);
      tick();
      chk("en_dato9", dato, 9);
      tick();
      chk("en_end_vacio", 32'(vacio), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/captura_salida.md
CAPTURA_SALIDA -- requirements
Module: captura_salida

Interface
REQ-001 Parameter WIDTH, default 32: width of the captured processor result word.
REQ-002 Parameter DEPTH, default 8: FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 Port salida_i, input, WIDTH: result word driven by the upstream single-cycle core (its salida_o).
REQ-006 Port en_i, input, 1: capture enable; when low, salida_i is ignored.
REQ-007 Port dato_o, output, WIDTH: oldest buffered word (head of FIFO).
REQ-008 Port valido_o, output, 1: dato_o holds a valid word.
REQ-009 Port listo_i, input, 1: downstream consumer accepts dato_o this cycle.
REQ-010 Port cuenta_o, output, log2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-011 Port lleno_o / vacio_o, output, 1 each: occupancy == DEPTH / occupancy == 0.
REQ-012 Port desborde_o, output, 1: sticky flag; a captured word was dropped.
REQ-013 Port perdidos_o, output, 16: count of dropped words, saturating.

Function
REQ-014 Block SHALL register the previous sample prev_q and a first-sample flag primero_q.
REQ-015 A capture request SHALL occur in a cycle where en_i=1 and (primero_q=1 or salida_i != prev_q).
REQ-016 prev_q SHALL load salida_i, and primero_q SHALL clear, in every cycle with en_i=1, whether or not the word is stored.
REQ-017 While en_i=0, prev_q and primero_q SHALL hold.
REQ-018 A pop SHALL occur exactly when valido_o=1 and listo_i=1.
REQ-019 A capture request SHALL be stored when occupancy < DEPTH, or when occupancy == DEPTH and a pop occurs in the same cycle.
REQ-020 Otherwise the request SHALL be dropped: desborde_o set, perdidos_o incremented, saturating at 16'hFFFF.
REQ-021 Simultaneous store and pop SHALL leave occupancy unchanged.
REQ-022 Output SHALL be first-word-fall-through: a word stored into an empty FIFO appears on dato_o with valido_o=1 one cycle after the capturing edge (latency 1).
REQ-023 dato_o SHALL remain stable while valido_o=1 and listo_i=0.
REQ-024 valido_o SHALL equal !vacio_o; listo_i with an empty FIFO SHALL have no effect.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; no other wrap handling is required.
REQ-026 Words SHALL leave in capture order, with no duplication or loss except the drops defined in REQ-020.

Reset
REQ-027 On a rising clk_i edge with rst_i=1:
- pointers and occupancy cleared;
- primero_q=1, prev_q=0;
- desborde_o=0, perdidos_o=0.
REQ-028 Reset SHALL take precedence over any simultaneous capture or pop. Entries in flight are discarded; storage contents need not be cleared.
REQ-029 During and after reset: valido_o=0, vacio_o=1, lleno_o=0, cuenta_o=0. dato_o is don't-care while valido_o=0.

Structure
REQ-030 Shared package captura_pkg SHALL hold WIDTH/DEPTH defaults, the derived PTR_W and CNT_W constants, and the perdidos saturation value.
REQ-031 Storage and pointer logic SHALL be one sub-module, fifo_sinc (push/pop/full/empty/count, FWFT).
REQ-032 Change detection and drop accounting SHALL be in the top level.

Verification
REQ-033 Reset release, then en_i=1, salida_i=32'h0000_0000 held 3 cycles, expected:
- exactly one word stored (first sample);
- dato_o=0 and valido_o=1 one cycle after capture;
- cuenta_o=1.
REQ-034 Stream salida_i=1,2,2,3 with en_i=1 and listo_i=1, expected:
- dato_o sequence 1,2,3;
- the repeated 2 is not stored.
REQ-035 listo_i=0 with 10 distinct values (DEPTH=8), expected:
- lleno_o=1, cuenta_o=8;
- perdidos_o=2, desborde_o=1;
- draining yields the first 8 values in order.
REQ-036 FIFO full, new distinct value and listo_i=1 in the same cycle, expected:
- word stored, cuenta_o stays 8;
- perdidos_o unchanged.
REQ-037 rst_i=1 for one cycle with cuenta_o=5 and desborde_o=1, expected next cycle:
- cuenta_o=0, valido_o=0, desborde_o=0, perdidos_o=0;
- the next en_i=1 sample is captured regardless of its value.
REQ-038 en_i=0 while salida_i changes 5->9, then en_i=1 with salida_i=9, expected:
- one capture of 9 (prev_q still 5);
- no captures while en_i=0.
